// File: rtl/prf_read_arbiter_if.sv
// Bundle of requester handshake, response and regfile read-port signals for prf_read_arbiter.
// The slave view is the arbiter. The master view is the surrounding pipeline plus the regfile.
interface prf_read_arbiter_if #(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int REG_DATA_WIDTH = 4
);
  logic                        flush;
  logic [5:0]                  req_valid;
  logic [6*REG_ADDR_WIDTH-1:0] req_addr;
  logic [5:0]                  req_ready;
  logic [5:0]                  rsp_valid;
  logic [6*REG_DATA_WIDTH-1:0] rsp_data;
  logic                        prf_rd0_en;
  logic [REG_ADDR_WIDTH-1:0]   prf_rd0_addr;
  logic [REG_DATA_WIDTH-1:0]   prf_rd0_data;
  logic                        prf_rd1_en;
  logic [REG_ADDR_WIDTH-1:0]   prf_rd1_addr;
  logic [REG_DATA_WIDTH-1:0]   prf_rd1_data;

  modport master (
    output flush, req_valid, req_addr, prf_rd0_data, prf_rd1_data,
    input  req_ready, rsp_valid, rsp_data,
           prf_rd0_en, prf_rd0_addr, prf_rd1_en, prf_rd1_addr
  );

  modport slave (
    input  flush, req_valid, req_addr, prf_rd0_data, prf_rd1_data,
    output req_ready, rsp_valid, rsp_data,
           prf_rd0_en, prf_rd0_addr, prf_rd1_en, prf_rd1_addr
  );
endinterface

// File: rtl/prf_read_arbiter.sv
// Round-robin arbiter of six read requesters onto two synchronous regfile read ports.
// Reads of register 0 are answered locally with zero and do not use a port.
module prf_read_arbiter #(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int REG_DATA_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  prf_read_arbiter_if.slave bus
);
  localparam int NREQ = 6;

  logic [2:0] r_rrPtr;
  logic       r_tagVld0;
  logic       r_tagVld1;
  logic [2:0] r_tagIdx0;
  logic [2:0] r_tagIdx1;
  logic [5:0] r_zeroPend;

  logic       w_active;
  logic [5:0] w_nzReq;
  logic [5:0] w_zeroReq;
  logic       w_found0;
  logic       w_found1;
  logic [2:0] w_idx0;
  logic [2:0] w_idx1;
  logic [3:0] w_sum;
  logic [2:0] w_cand;
  logic [2:0] w_lastIdx;
  logic [2:0] w_rrNext;
  logic [5:0] w_ready;
  logic [5:0] w_rspValid;
  logic [6*REG_DATA_WIDTH-1:0] w_rspData;

  // Reset is folded in so grants and port enables drop immediately, not at the next edge.
  assign w_active = rstn && !bus.flush;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_nzReq[i]   = bus.req_valid[i] && (bus.req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0);
      w_zeroReq[i] = bus.req_valid[i] && (bus.req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0);
    end
  end

  always_comb begin
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_idx0   = '0;
    w_idx1   = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rrPtr} + 4'(k);
      if (w_sum >= 4'd6) w_sum = w_sum - 4'd6;
      w_cand = w_sum[2:0];
      if (w_nzReq[w_cand]) begin
        if (!w_found0) begin
          w_found0 = 1'b1;
          w_idx0   = w_cand;
        end else if (!w_found1) begin
          w_found1 = 1'b1;
          w_idx1   = w_cand;
        end
      end
    end
  end

  assign w_lastIdx = w_found1 ? w_idx1 : w_idx0;
  assign w_rrNext  = (w_lastIdx == 3'd5) ? 3'd0 : w_lastIdx + 3'd1;

  always_comb begin
    w_ready = '0;
    if (w_active) begin
      w_ready = w_zeroReq;
      if (w_found0) w_ready[w_idx0] = 1'b1;
      if (w_found1) w_ready[w_idx1] = 1'b1;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.prf_rd0_en   = w_active && w_found0;
  assign bus.prf_rd0_addr = (w_active && w_found0) ? bus.req_addr[w_idx0*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] : '0;
  assign bus.prf_rd1_en   = w_active && w_found1;
  assign bus.prf_rd1_addr = (w_active && w_found1) ? bus.req_addr[w_idx1*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] : '0;

  // Responses route this cycle's regfile data to whoever was granted last cycle.
  always_comb begin
    w_rspValid = r_zeroPend;
    w_rspData  = '0;
    if (r_tagVld0) begin
      w_rspValid[r_tagIdx0] = 1'b1;
      w_rspData[r_tagIdx0*REG_DATA_WIDTH +: REG_DATA_WIDTH] = bus.prf_rd0_data;
    end
    if (r_tagVld1) begin
      w_rspValid[r_tagIdx1] = 1'b1;
      w_rspData[r_tagIdx1*REG_DATA_WIDTH +: REG_DATA_WIDTH] = bus.prf_rd1_data;
    end
  end

  assign bus.rsp_valid = w_rspValid;
  assign bus.rsp_data  = w_rspData;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rrPtr    <= '0;
      r_tagVld0  <= 1'b0;
      r_tagVld1  <= 1'b0;
      r_tagIdx0  <= '0;
      r_tagIdx1  <= '0;
      r_zeroPend <= '0;
    end else if (bus.flush) begin
      r_tagVld0  <= 1'b0;
      r_tagVld1  <= 1'b0;
      r_zeroPend <= '0;
    end else begin
      r_tagVld0  <= w_found0;
      r_tagVld1  <= w_found1;
      r_tagIdx0  <= w_idx0;
      r_tagIdx1  <= w_idx1;
      r_zeroPend <= w_zeroReq;
      if (w_found0) r_rrPtr <= w_rrNext;
    end
  end
endmodule

// File: tb/tb_prf_read_arbiter.sv
// Randomised and directed bench for prf_read_arbiter against a queue-based round-robin model.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_prf_read_arbiter;
  localparam int AW = 3;
  localparam int DW = 4;
  localparam int NR = 6;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  prf_read_arbiter_if #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) bus ();

  prf_read_arbiter #(.REG_ADDR_WIDTH(AW), .REG_DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model state: next requester in the rotation, and what each requester expects next cycle
  // (0 nothing, 1 zero reply, 2 data from port 0, 3 data from port 1).
  int         mRr;
  int         mKind[NR];
  logic [5:0] mReady;
  logic [5:0] obsReady;
  logic [2:0] obsAddr0;
  logic [5:0] obsRspValid;
  int         grantCount[NR];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [17:0] packAddr(input int a0, a1, a2, a3, a4, a5);
    logic [17:0] r;
    r = {3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    return r;
  endfunction

  task automatic modelReset();
    mRr = 0;
    for (int i = 0; i < NR; i++) mKind[i] = 0;
  endtask

  task automatic applyStimulus(input logic [5:0] v, input logic [17:0] a, input logic f,
                               input logic [3:0] d0, input logic [3:0] d1);
    int         q[$];
    int         ai;
    logic [5:0] expReady;
    logic [5:0] expRspV;
    logic [23:0] expRspD;
    logic       expE0, expE1;
    logic [2:0] expA0, expA1;

    @(negedge clk);
    bus.req_valid    = v;
    bus.req_addr     = a;
    bus.flush        = f;
    bus.prf_rd0_data = d0;
    bus.prf_rd1_data = d1;
    #1;

    expRspV = '0;
    expRspD = '0;
    for (int i = 0; i < NR; i++) begin
      if (mKind[i] != 0) expRspV[i] = 1'b1;
      if (mKind[i] == 2) expRspD[i*DW +: DW] = d0;
      if (mKind[i] == 3) expRspD[i*DW +: DW] = d1;
    end

    expReady = '0;
    if (!f) begin
      for (int k = 0; k < NR; k++) begin
        ai = (mRr + k) % NR;
        if (v[ai]) begin
          if (a[ai*AW +: AW] == 3'd0) expReady[ai] = 1'b1;
          else q.push_back(ai);
        end
      end
    end
    expE0 = (q.size() > 0);
    expE1 = (q.size() > 1);
    expA0 = expE0 ? a[q[0]*AW +: AW] : 3'd0;
    expA1 = expE1 ? a[q[1]*AW +: AW] : 3'd0;
    if (expE0) expReady[q[0]] = 1'b1;
    if (expE1) expReady[q[1]] = 1'b1;

    obsReady    = bus.req_ready;
    obsAddr0    = bus.prf_rd0_addr;
    obsRspValid = bus.rsp_valid;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
    checkOutput("rd0_en",    32'(bus.prf_rd0_en), 32'(expE0));
    checkOutput("rd0_addr",  32'(bus.prf_rd0_addr), 32'(expA0));
    checkOutput("rd1_en",    32'(bus.prf_rd1_en), 32'(expE1));
    checkOutput("rd1_addr",  32'(bus.prf_rd1_addr), 32'(expA1));
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expRspV));
    checkOutput("rsp_data",  32'(bus.rsp_data), 32'(expRspD));

    for (int i = 0; i < NR; i++) begin
      mKind[i] = 0;
      if (obsReady[i]) grantCount[i]++;
    end
    if (!f) begin
      for (int i = 0; i < NR; i++)
        if (v[i] && a[i*AW +: AW] == 3'd0) mKind[i] = 1;
      if (expE0) mKind[q[0]] = 2;
      if (expE1) mKind[q[1]] = 3;
      if (expE1) mRr = (q[1] + 1) % NR;
      else if (expE0) mRr = (q[0] + 1) % NR;
    end
    mReady = expReady;
  endtask

  task automatic resetMidTraffic(input logic [5:0] v, input logic [17:0] a);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.flush     = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("rst_ready",  32'(bus.req_ready), 32'd0);
    checkOutput("rst_rspv",   32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rspd",   32'(bus.rsp_data), 32'd0);
    checkOutput("rst_rd0_en", 32'(bus.prf_rd0_en), 32'd0);
    checkOutput("rst_rd1_en", 32'(bus.prf_rd1_en), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_rspv", 32'(bus.rsp_valid), 32'd0);
    rstn = 1'b1;
    modelReset();
  endtask

  logic [5:0]  stV;
  logic [17:0] stA;
  logic        stF;

  initial begin
    modelReset();
    for (int i = 0; i < NR; i++) grantCount[i] = 0;
    rstn             = 1'b0;
    bus.flush        = 1'b0;
    bus.req_valid    = 6'b111111;
    bus.req_addr     = packAddr(1, 2, 3, 4, 5, 6);
    bus.prf_rd0_data = 4'h0;
    bus.prf_rd1_data = 4'h0;
    #3;
    checkOutput("init_ready",  32'(bus.req_ready), 32'd0);
    checkOutput("init_rspv",   32'(bus.rsp_valid), 32'd0);
    checkOutput("init_rd0_en", 32'(bus.prf_rd0_en), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Basic two-step rotation.
    applyStimulus(6'b001111, packAddr(5, 6, 7, 1, 0, 0), 1'b0, 4'h1, 4'h2);
    checkOutput("basic1_ready", 32'(obsReady), 32'(6'b000011));
    checkOutput("basic1_addr0", 32'(obsAddr0), 32'd5);
    applyStimulus(6'b001111, packAddr(5, 6, 7, 1, 0, 0), 1'b0, 4'hA, 4'hB);
    checkOutput("basic2_ready", 32'(obsReady), 32'(6'b001100));
    checkOutput("basic2_rspv",  32'(obsRspValid), 32'(6'b000011));

    // Wrap from pointer 4.
    applyStimulus(6'b100001, packAddr(3, 0, 0, 0, 0, 2), 1'b0, 4'h3, 4'h4);
    checkOutput("wrap_ready", 32'(obsReady), 32'(6'b100001));
    checkOutput("wrap_addr0", 32'(obsAddr0), 32'd2);

    // All register-0 reads.
    applyStimulus(6'b111111, packAddr(0, 0, 0, 0, 0, 0), 1'b0, 4'h5, 4'h6);
    checkOutput("zero_ready", 32'(obsReady), 32'(6'b111111));
    applyStimulus(6'b000000, packAddr(0, 0, 0, 0, 0, 0), 1'b0, 4'h7, 4'h8);
    checkOutput("zero_rspv", 32'(obsRspValid), 32'(6'b111111));

    // Grant 2 and 4, then flush the following cycle.
    applyStimulus(6'b010100, packAddr(0, 0, 3, 0, 4, 0), 1'b0, 4'h1, 4'h1);
    checkOutput("flush_pre_ready", 32'(obsReady), 32'(6'b010100));
    applyStimulus(6'b111110, packAddr(0, 1, 2, 3, 4, 5), 1'b1, 4'h9, 4'hC);
    checkOutput("flush_ready", 32'(obsReady), 32'd0);
    checkOutput("flush_rspv",  32'(obsRspValid), 32'(6'b010100));
    applyStimulus(6'b111110, packAddr(0, 1, 2, 3, 4, 5), 1'b0, 4'hD, 4'hE);
    checkOutput("flush_post_rspv", 32'(obsRspValid), 32'd0);

    // Reset with responses in flight, then fairness from requester 0.
    resetMidTraffic(6'b111111, packAddr(1, 2, 3, 4, 5, 6));
    for (int i = 0; i < NR; i++) grantCount[i] = 0;
    for (int c = 0; c < 9; c++) begin
      applyStimulus(6'b111111, packAddr(1, 2, 3, 4, 5, 6), 1'b0,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (c == 0) checkOutput("starve_first_ready", 32'(obsReady), 32'(6'b000011));
    end
    for (int i = 0; i < NR; i++) checkOutput($sformatf("starve_count%0d", i), 32'(grantCount[i]), 32'd3);

    // Random traffic; ungranted requests are held stable as the protocol demands.
    stV = '0;
    stA = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!stV[i] || mReady[i]) begin
          stV[i] = ($urandom_range(0, 3) != 0);
          stA[i*AW +: AW] = 3'($urandom_range(0, 7));
        end
      end
      stF = ($urandom_range(0, 9) == 0);
      applyStimulus(stV, stA, stF, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (c == 1500) begin
        resetMidTraffic(stV, stA);
        mReady = '0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
